// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (DM).
// DM wins by default; IF is forced after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   input  logic [3:0]    dm_be,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int LW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT);
   localparam logic [LW-1:0] LAT_ONE    = LW'(1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

   state_t        r_state, w_state_nxt;
   owner_t        r_owner, w_owner_nxt;
   logic [LW-1:0] r_lat_cnt, w_lat_nxt;
   logic [SW-1:0] r_starve_cnt, w_starve_nxt;
   logic          w_resp, w_win, w_gnt_if, w_gnt_dm;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_owner      <= OWN_NONE;
         r_lat_cnt    <= '0;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_lat_cnt    <= w_lat_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // The response cycle doubles as a grant window so grants can overlap it.
   always_comb begin
      w_resp = !Reset && (r_state == S_WAIT) && (r_lat_cnt == LAT_ONE);
      w_win  = !Reset && ((r_state == S_IDLE) || w_resp);
      w_gnt_dm = w_win && dm_req &&
                 !(if_req && (r_starve_cnt == STARVE_TOP));
      w_gnt_if = w_win && if_req && !w_gnt_dm;

      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_lat_nxt    = r_lat_cnt;
      w_starve_nxt = r_starve_cnt;

      if (w_gnt_if || w_gnt_dm) begin
         w_state_nxt = S_WAIT;
         w_lat_nxt   = LAT_INIT;
         w_owner_nxt = w_gnt_dm ? OWN_DM : OWN_IF;
      end else if (r_state == S_WAIT) begin
         if (r_lat_cnt == LAT_ONE) begin
            w_state_nxt = S_IDLE;
            w_lat_nxt   = '0;
            w_owner_nxt = OWN_NONE;
         end else begin
            w_lat_nxt = r_lat_cnt - 1'b1;
         end
      end

      if (w_win) begin
         if (if_req && w_gnt_dm) begin
            if (r_starve_cnt != STARVE_TOP)
               w_starve_nxt = r_starve_cnt + 1'b1;
         end else begin
            w_starve_nxt = '0;
         end
      end
   end

   always_comb begin
      if_gnt    = w_gnt_if;
      dm_gnt    = w_gnt_dm;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = 4'h0;
      unique case (1'b1)
         w_gnt_if: begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            mem_be   = 4'hF;
         end
         w_gnt_dm: begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_be    = dm_be;
         end
         default: ;
      endcase
   end

   always_comb begin
      if_rvalid = w_resp && (r_owner == OWN_IF);
      dm_rvalid = w_resp && (r_owner == OWN_DM);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      dm_rdata  = dm_rvalid ? mem_rdata : '0;
      busy      = !Reset && (r_state == S_WAIT);
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory of the simple MIPS core between the instruction-fetch requester (IF) and the load/store requester (DM).
- Sits between the fetch/LSU front ends and the memory macro.
- One transaction is outstanding at a time; a new grant can overlap the response cycle.
- DM has fixed priority over IF, with an anti-starvation counter that forces an IF grant.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from a mem_en cycle to mem_rdata valid; legal range is MEM_LAT >= 1.
- STARVE_MAX, 4, consecutive DM wins over a pending IF request before IF is forced; legal range is STARVE_MAX >= 1.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DW  fetch data.
- dm_req  in  1  data request; held with its fields until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_be  in  4  store byte enables.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid, or store acknowledge; one-cycle pulse.
- dm_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  transaction outstanding.

Behaviour:
- Reset behaviour:
  - While Reset=1, every output is 0: gnts, rvalids, rdata, all mem_* signals and busy.
  - At the next edge: state=IDLE, lat_cnt=0, starve_cnt=0, owner=NONE.
  - A transaction in flight when Reset asserts is discarded; its rvalid never appears.
- FSM states are IDLE and WAIT.
- Grant window:
  - Open when state=IDLE, or state=WAIT with lat_cnt==1 (the response cycle).
  - Also requires Reset=0.
- Arbitration inside the grant window:
  - Only one requester active: grant it.
  - Both active and starve_cnt==STARVE_MAX: grant IF.
  - Both active otherwise: grant DM.
- Grant cycle outputs:
  - gnt is combinational in the grant cycle.
  - mem_en=1 and mem_* are driven combinationally from the granted requester in the same cycle.
  - For IF: mem_we=0, mem_be=4'hF.
  - Exactly one gnt may be high in any cycle.
- Outside the grant window or with no request: gnts=0, mem_en=0, mem_we=0.
- After a grant:
  - state=WAIT, lat_cnt=MEM_LAT, owner=granted side.
  - In WAIT, lat_cnt decrements each cycle.
- Response cycle (lat_cnt==1):
  - The owner's rvalid=1 and its rdata=mem_rdata, passed through combinationally.
  - The other rvalid stays 0.
  - Next state: WAIT with the new owner if a grant occurred in the same cycle, otherwise IDLE.
- Store responses:
  - dm_rvalid still pulses MEM_LAT cycles after the grant, as the acknowledge.
  - dm_rdata is don't-care but must be stable; it is driven from mem_rdata.
- Latency and throughput:
  - Response arrives exactly MEM_LAT cycles after the grant.
  - Peak throughput is one grant per MEM_LAT cycles.
  - With MEM_LAT=1 the block sustains one grant per cycle.
- starve_cnt, evaluated each grant-window cycle:
  - if_req=1 and DM granted: increment, saturating at STARVE_MAX.
  - IF granted or if_req=0: clear to 0.
  - Unchanged outside grant windows.
- busy = (state==WAIT).
- The rdata outputs are 0 whenever their rvalid is 0.
- Requests whose req drops before gnt are simply not served; no error is flagged.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x0; the memory model returns 0x3C10FFFF.
   - Required: if_gnt=1 at cycle t with mem_addr=0x0 and mem_we=0.
   - Required: if_rvalid=1 with if_rdata=0x3C10FFFF at t+1.
2. if_req and dm_req (load, addr 0x40) rise in the same cycle with MEM_LAT=1.
   - Required: dm_gnt at t; if_gnt at t+1, overlapping dm_rvalid.
   - Required: if_rvalid at t+2.
3. dm_req and if_req held high continuously with STARVE_MAX=4.
   - Required: dm_gnt on 4 consecutive grant windows, then if_gnt on the 5th, then DM resumes.
   - Required: no cycle has both gnts high.
4. Store: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF, dm_be=0xF.
   - Required at grant cycle: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF.
   - Required one cycle later: dm_rvalid=1 and if_rvalid=0.
5. if_gnt at cycle t with MEM_LAT=3, then Reset=1 at t+1 for one cycle.
   - Required: if_rvalid never pulses for that fetch.
   - Required: busy=0 from t+1.
   - Required: a new if_req after reset is granted in its first cycle.
6. MEM_LAT=3, IF-only back-to-back requests.
   - Required: grants at t, t+3, t+6.
   - Required: rvalids at t+3, t+6, t+9.
   - Required: busy held 1 throughout.
